// File: rtl/mem_access_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// Data normally wins; a pending fetch is always served right after a data grant.
module mem_access_arbiter #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [31:0]       if_data,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_ready,
   output logic [31:0]       dm_rdata,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              stall
);

   localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      FETCH,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic              fetch_pri_q, fetch_pri_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic              if_ready_q, if_ready_d;
   logic              dm_ready_q, dm_ready_d;
   logic              err_q, err_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       dm_rdata_q, dm_rdata_d;

   logic dm_req;
   logic grant_dm;
   logic dm_misal;
   logic if_misal;

   assign dm_req   = dm_read | dm_write;
   assign grant_dm = dm_req & ~(fetch_pri_q & if_req);
   assign dm_misal = dm_addr[1:0] != 2'b00;
   assign if_misal = if_addr[1:0] != 2'b00;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         fetch_pri_q <= 1'b0;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         err_q       <= 1'b0;
         if_data_q   <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pri_q <= fetch_pri_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         err_q       <= err_d;
         if_data_q   <= if_data_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fetch_pri_d = fetch_pri_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      err_d       = 1'b0;
      if_data_d   = if_data_q;
      dm_rdata_d  = dm_rdata_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (grant_dm) begin
               fetch_pri_d = 1'b1;
               if (dm_misal) begin
                  state_d    = RESP;
                  dm_ready_d = 1'b1;
                  err_d      = 1'b1;
                  dm_rdata_d = '0;
               end else begin
                  state_d     = DATA;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  mem_wr_d    = dm_write;
                  mem_rd_d    = dm_read & ~dm_write;
               end
            end else if (if_req) begin
               fetch_pri_d = 1'b0;
               if (if_misal) begin
                  state_d    = RESP;
                  if_ready_d = 1'b1;
                  err_d      = 1'b1;
                  if_data_d  = '0;
               end else begin
                  state_d     = FETCH;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  mem_wr_d    = 1'b0;
                  mem_rd_d    = 1'b1;
               end
            end
         end

         DATA, FETCH: begin
            if (mem_ack) begin
               state_d  = RESP;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               if (state_q == DATA) begin
                  dm_ready_d = 1'b1;
                  // a store completion keeps the last load value
                  if (!mem_wr_q) begin
                     dm_rdata_d = mem_rdata;
                  end
               end else begin
                  if_ready_d = 1'b1;
                  if_data_d  = mem_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d  = RESP;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               err_d    = 1'b1;
               if (state_q == DATA) begin
                  dm_ready_d = 1'b1;
                  dm_rdata_d = '0;
               end else begin
                  if_ready_d = 1'b1;
                  if_data_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign if_ready  = if_ready_q;
   assign dm_ready  = dm_ready_q;
   assign err       = err_q;
   assign if_data   = if_data_q;
   assign dm_rdata  = dm_rdata_q;

   assign stall = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: expected grants and responses
// are queued by the directed sequence and popped by negedge monitors.
module tb_mem_access_arbiter;

   typedef struct {
      logic        dm;
      logic        err;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
   } gnt_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_data;
   logic        dm_read;
   logic        dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ready;
   logic [31:0] dm_rdata;
   logic        err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall;

   logic        auto_ack;
   logic        man_ack;
   logic [31:0] auto_rdata;
   bit          ack_en;
   int          ack_delay;
   int          last_len;
   int          checks;
   int          errors;

   resp_t exp_q[$];
   gnt_t  gnt_q[$];

   assign mem_ack   = auto_ack | man_ack;
   assign mem_rdata = auto_rdata;

   always #5 clock = ~clock;

   mem_access_arbiter dut (
      .clock    (clock),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ready (if_ready),
      .if_data  (if_data),
      .dm_read  (dm_read),
      .dm_write (dm_write),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_ready (dm_ready),
      .dm_rdata (dm_rdata),
      .err      (err),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .stall    (stall)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h40:  return 32'h8C010004;
         32'h44:  return 32'h33334444;
         32'h48:  return 32'h55556666;
         32'h4C:  return 32'h9999AAAA;
         32'h50:  return 32'hDDDDEEEE;
         32'h100: return 32'h11112222;
         32'h104: return 32'h77778888;
         32'h108: return 32'hBBBBCCCC;
         default: return 32'hFFFF0000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_r(input logic d, input logic e, input logic [31:0] v);
      resp_t r;
      r.dm = d;
      r.err = e;
      r.data = v;
      exp_q.push_back(r);
   endtask

   task automatic push_g(input logic [31:0] a, input logic [31:0] w,
                         input logic rd, input logic wr);
      gnt_t g;
      g.addr = a;
      g.wdata = w;
      g.rd = rd;
      g.wr = wr;
      gnt_q.push_back(g);
   endtask

   task automatic responder();
      int seen = 0;
      forever begin
         @(negedge clock);
         auto_rdata = mem_word(mem_addr);
         if (ack_en && (mem_rd || mem_wr) && !reset) begin
            if (seen >= ack_delay) begin
               auto_ack = 1'b1;
               seen = 0;
            end else begin
               auto_ack = 1'b0;
               seen++;
            end
         end else begin
            auto_ack = 1'b0;
            seen = 0;
         end
      end
   endtask

   task automatic resp_mon();
      resp_t e;
      logic [31:0] got;
      forever begin
         @(negedge clock);
         if (!reset && (if_ready || dm_ready)) begin
            checks++;
            got = dm_ready ? dm_rdata : if_data;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected: if_ready=%b dm_ready=%b data=%h",
                        if_ready, dm_ready, got);
            end else begin
               e = exp_q.pop_front();
               if (if_ready && dm_ready || dm_ready !== e.dm ||
                   err !== e.err || got !== e.data) begin
                  errors++;
                  $display("FAIL resp: got if_rdy=%b dm_rdy=%b err=%b data=%h expected dm=%b err=%b data=%h",
                           if_ready, dm_ready, err, got, e.dm, e.err, e.data);
               end
            end
         end
      end
   endtask

   task automatic grant_mon();
      logic prev = 1'b0;
      logic strb;
      int   len = 0;
      gnt_t g;
      forever begin
         @(negedge clock);
         strb = mem_rd | mem_wr;
         if (strb && !prev) begin
            len = 1;
            checks++;
            if (gnt_q.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected: addr=%h rd=%b wr=%b",
                        mem_addr, mem_rd, mem_wr);
            end else begin
               g = gnt_q.pop_front();
               if (mem_addr !== g.addr || mem_rd !== g.rd || mem_wr !== g.wr ||
                   (g.wr && mem_wdata !== g.wdata)) begin
                  errors++;
                  $display("FAIL grant: got addr=%h wd=%h rd=%b wr=%b expected addr=%h wd=%h rd=%b wr=%b",
                           mem_addr, mem_wdata, mem_rd, mem_wr,
                           g.addr, g.wdata, g.rd, g.wr);
               end
            end
         end else if (strb) begin
            len++;
         end else if (prev) begin
            last_len = len;
         end
         prev = strb;
      end
   endtask

   task automatic fetch_req(input logic [31:0] a, input bit hold, output int lat);
      if_addr = a;
      if_req = 1'b1;
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clock);
         if (if_ready) begin
            lat = c;
            break;
         end
         chk("stall_if", {31'b0, stall}, 32'h1);
      end
      chk("fetch_done", {31'b0, lat != 0}, 32'h1);
      if (!hold) if_req = 1'b0;
   endtask

   task automatic dm_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, output int lat);
      dm_read = rd;
      dm_write = wr;
      dm_addr = a;
      dm_wdata = wd;
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clock);
         if (dm_ready) begin
            lat = c;
            break;
         end
         chk("stall_dm", {31'b0, stall}, 32'h1);
      end
      chk("dm_done", {31'b0, lat != 0}, 32'h1);
      if (!hold) begin
         dm_read = 1'b0;
         dm_write = 1'b0;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_if_ready"}, {31'b0, if_ready}, 32'h0);
      chk({tag, "_dm_ready"}, {31'b0, dm_ready}, 32'h0);
      chk({tag, "_err"}, {31'b0, err}, 32'h0);
      chk({tag, "_mem_rd"}, {31'b0, mem_rd}, 32'h0);
      chk({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, "_if_data"}, if_data, 32'h0);
      chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int la, lb;
      reset = 1'b1;
      if_req = 1'b0;
      if_addr = '0;
      dm_read = 1'b0;
      dm_write = 1'b0;
      dm_addr = '0;
      dm_wdata = '0;
      auto_ack = 1'b0;
      man_ack = 1'b0;
      auto_rdata = '0;
      ack_en = 1'b1;
      ack_delay = 0;
      last_len = 0;
      checks = 0;
      errors = 0;
      fork
         responder();
         resp_mon();
         grant_mon();
      join_none

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_reset_vals("rst");
      chk("rst_stall", {31'b0, stall}, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      // fetch with ack one cycle after mem_rd
      ack_delay = 1;
      push_g(32'h40, 32'h0, 1'b1, 1'b0);
      push_r(1'b0, 1'b0, 32'h8C010004);
      fetch_req(32'h40, 1'b0, la);
      @(negedge clock);
      chk("fetch_rd_len", last_len, 32'd2);
      chk("fetch_lat_d1", la, 32'd3);

      // simultaneous data and fetch: data first
      ack_delay = 0;
      push_g(32'h100, 32'h0, 1'b1, 1'b0);
      push_g(32'h48, 32'h0, 1'b1, 1'b0);
      push_r(1'b1, 1'b0, 32'h11112222);
      push_r(1'b0, 1'b0, 32'h55556666);
      fork
         dm_req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, la);
         fetch_req(32'h48, 1'b0, lb);
      join
      @(negedge clock);

      // data held continuously against pending fetch
      push_g(32'h104, 32'h0, 1'b1, 1'b0);
      push_g(32'h4C, 32'h0, 1'b1, 1'b0);
      push_g(32'h108, 32'h0, 1'b1, 1'b0);
      push_g(32'h50, 32'h0, 1'b1, 1'b0);
      push_r(1'b1, 1'b0, 32'h77778888);
      push_r(1'b0, 1'b0, 32'h9999AAAA);
      push_r(1'b1, 1'b0, 32'hBBBBCCCC);
      push_r(1'b0, 1'b0, 32'hDDDDEEEE);
      fork
         begin
            int l1;
            dm_req(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, l1);
            dm_req(1'b1, 1'b0, 32'h108, 32'h0, 1'b0, l1);
         end
         begin
            int l2;
            fetch_req(32'h4C, 1'b1, l2);
            fetch_req(32'h50, 1'b0, l2);
         end
      join
      @(negedge clock);

      // store leaves dm_rdata at last load value
      push_g(32'h200, 32'hDEADBEEF, 1'b0, 1'b1);
      push_r(1'b1, 1'b0, 32'hBBBBCCCC);
      dm_req(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, la);
      @(negedge clock);

      // misaligned data address: no strobe, fast error
      push_r(1'b1, 1'b1, 32'h0);
      dm_req(1'b1, 1'b0, 32'h202, 32'h0, 1'b0, la);
      chk("misal_lat_le2", {31'b0, la <= 2}, 32'h1);
      @(negedge clock);

      // timeout with no ack
      ack_en = 1'b0;
      push_g(32'h60, 32'h0, 1'b1, 1'b0);
      push_r(1'b0, 1'b1, 32'h0);
      fetch_req(32'h60, 1'b0, la);
      @(negedge clock);
      chk("timeout_rd_len", last_len, 32'd15);
      chk("timeout_lat", la, 32'd16);
      ack_en = 1'b1;

      // stray ack while idle
      man_ack = 1'b1;
      repeat (2) begin
         @(negedge clock);
         chk("idle_ack_rdy", {31'b0, if_ready | dm_ready}, 32'h0);
      end
      man_ack = 1'b0;
      chk("idle_ack_rd", {31'b0, mem_rd}, 32'h0);

      // minimum latency load and fetch
      push_g(32'h100, 32'h0, 1'b1, 1'b0);
      push_r(1'b1, 1'b0, 32'h11112222);
      dm_req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, la);
      chk("dm_lat_min", la, 32'd2);
      @(negedge clock);
      push_g(32'h44, 32'h0, 1'b1, 1'b0);
      push_r(1'b0, 1'b0, 32'h33334444);
      fetch_req(32'h44, 1'b0, la);
      chk("if_lat_min", la, 32'd2);
      @(negedge clock);

      // reset during fetch, then late ack
      ack_en = 1'b0;
      push_g(32'h68, 32'h0, 1'b1, 1'b0);
      if_addr = 32'h68;
      if_req = 1'b1;
      repeat (3) @(negedge clock);
      chk("midrst_rd", {31'b0, mem_rd}, 32'h1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      if_req = 1'b0;
      man_ack = 1'b1;
      @(negedge clock);
      @(negedge clock);
      man_ack = 1'b0;
      chk_reset_vals("midrst");
      ack_en = 1'b1;

      // normal operation after reset
      push_g(32'h104, 32'h0, 1'b1, 1'b0);
      push_r(1'b1, 1'b0, 32'h77778888);
      dm_req(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, la);

      repeat (3) @(negedge clock);
      chk("resp_q_empty", exp_q.size(), 32'd0);
      chk("gnt_q_empty", gnt_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
